// File: rtl/uart_text_writer.sv
// UART-to-text-RAM writer: turns received bytes into character RAM writes,
// tracks a cursor, handles CR/LF/BS, wraps lines/rows and blanks new rows.
`timescale 1ns/1ps
module uart_text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      drdy,
  input  logic [7:0]                data,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [7:0]                ram_wdata,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy,
  output logic                      overflow
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COL_END   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        BLANK     = 8'h20;

  typedef enum logic [1:0] {INIT_CLR, IDLE, WRITE, ROW_CLR} state_t;

  state_t            state, state_n;
  logic              drdy_q;
  logic              pend_v, pend_v_n;
  logic [7:0]        pend_byte, pend_byte_n;
  logic [7:0]        cur_byte, cur_byte_n;
  logic              ovf_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [CW-1:0]     col, col_n;
  logic [RW-1:0]     row, row_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;
  logic              accept;
  logic              consume;
  logic [RW-1:0]     row_inc;
  logic [ADDR_W-1:0] row_base;

  assign accept     = drdy & ~drdy_q;
  assign consume    = (state == IDLE) & pend_v;
  assign row_inc    = (row == ROW_LAST) ? '0 : row + RW'(1);
  assign row_base   = ADDR_W'(row) * COLS_A;
  assign busy       = (state != IDLE) | pend_v;
  assign cursor_col = col;
  assign cursor_row = row;

  // One-entry pending buffer: a new byte is dropped only if the slot is
  // still occupied and not being drained on this same edge.
  always_comb begin
    pend_v_n    = pend_v;
    pend_byte_n = pend_byte;
    ovf_n       = overflow;
    if (consume) pend_v_n = 1'b0;
    if (accept) begin
      if (pend_v && !consume) begin
        ovf_n = 1'b1;
      end else begin
        pend_v_n    = 1'b1;
        pend_byte_n = data;
      end
    end
  end

  // Next-state, cursor and RAM write decode.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    col_n      = col;
    row_n      = row;
    cur_byte_n = cur_byte;
    we_n       = 1'b0;
    addr_n     = ram_addr;
    wdata_n    = ram_wdata;
    case (state)
      INIT_CLR: begin
        we_n    = 1'b1;
        addr_n  = cnt;
        wdata_n = BLANK;
        if (cnt == CELL_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (pend_v) begin
          cur_byte_n = pend_byte;
          state_n    = WRITE;
        end
      end
      WRITE: begin
        state_n = IDLE;
        if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
          we_n    = 1'b1;
          addr_n  = row_base + ADDR_W'(col);
          wdata_n = cur_byte;
          if (col == COL_LAST) begin
            col_n   = '0;
            row_n   = row_inc;
            cnt_n   = '0;
            state_n = ROW_CLR;
          end else begin
            col_n = col + CW'(1);
          end
        end else if (cur_byte == 8'h0D) begin
          col_n = '0;
        end else if (cur_byte == 8'h0A) begin
          col_n   = '0;
          row_n   = row_inc;
          cnt_n   = '0;
          state_n = ROW_CLR;
        end else if (cur_byte == 8'h08 && col != '0) begin
          col_n   = col - CW'(1);
          we_n    = 1'b1;
          addr_n  = row_base + ADDR_W'(col - CW'(1));
          wdata_n = BLANK;
        end
      end
      ROW_CLR: begin
        we_n    = 1'b1;
        addr_n  = row_base + cnt;
        wdata_n = BLANK;
        if (cnt == COL_END) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ADDR_W'(1);
        end
      end
      default: state_n = INIT_CLR;
    endcase
  end

  // FSM, cursor and registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_CLR;
      cnt       <= '0;
      col       <= '0;
      row       <= '0;
      cur_byte  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= BLANK;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      col       <= col_n;
      row       <= row_n;
      cur_byte  <= cur_byte_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
    end
  end

  // Byte-ready edge detect, pending slot and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      drdy_q    <= 1'b0;
      pend_v    <= 1'b0;
      pend_byte <= '0;
      overflow  <= 1'b0;
    end else begin
      drdy_q    <= drdy;
      pend_v    <= pend_v_n;
      pend_byte <= pend_byte_n;
      overflow  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_uart_text_writer.sv
// Bench for uart_text_writer: a screen-level model predicts the ordered
// stream of RAM writes and the cursor; directed cases pin exact latencies.
`timescale 1ns/1ps
module tb_uart_text_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int CELLS  = COLS * ROWS;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    drdy = 1'b0;
  logic [7:0]              data = 8'h00;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [7:0]              ram_wdata;
  logic [$clog2(COLS)-1:0] cursor_col;
  logic [$clog2(ROWS)-1:0] cursor_row;
  logic                    busy;
  logic                    overflow;

  always #5 clk = ~clk;

  uart_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .drdy(drdy), .data(data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: expected write stream plus cursor/overflow.
  int unsigned exp_addr[$];
  logic [7:0]  exp_data[$];
  int unsigned m_col, m_row;
  logic        m_ovf;
  int unsigned last_addr;
  logic [7:0]  last_data;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_w(input int unsigned a, input logic [7:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endfunction

  function automatic void model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) push_w(m_row * COLS + c, 8'h20);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(m_row * COLS + m_col, b);
      if (m_col == COLS - 1) model_newline();
      else m_col++;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      model_newline();
    end else if (b == 8'h08 && m_col > 0) begin
      m_col--;
      push_w(m_row * COLS + m_col, 8'h20);
    end
  endfunction

  function automatic void model_reset();
    exp_addr.delete();
    exp_data.delete();
    m_col = 0;
    m_row = 0;
    m_ovf = 1'b0;
    for (int a = 0; a < CELLS; a++) push_w(a, 8'h20);
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
      5: b = 8'h0D;
      6: b = 8'h0A;
      7: b = 8'h08;
      8: b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    int unsigned ea;
    logic [7:0]  ed;
    #1;
    if (!rst) begin
      if (ram_we) begin
        n_cmp++;
        if (exp_addr.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", ram_addr, ram_wdata);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check("write_addr", ram_addr, ea);
          check("write_data", ram_wdata, ed);
        end
        last_addr = ram_addr;
        last_data = ram_wdata;
      end
      if (!busy) begin
        check("idle_queue_empty", exp_addr.size(), 0);
        check("idle_col", cursor_col, m_col);
        check("idle_row", cursor_row, m_row);
      end
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    drdy = 1'b1;
    model_byte(b);
    @(negedge clk);
    drdy = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic expect_write(input string name, input int unsigned a, input logic [7:0] d);
    @(negedge clk);
    check({name, "_we"}, ram_we, 1);
    check({name, "_addr"}, ram_addr, a);
    check({name, "_data"}, ram_wdata, d);
  endtask

  task automatic expect_quiet(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      check(name, ram_we, 0);
    end
  endtask

  // Returns at the negedge where rst is released (next posedge is the first write).
  task automatic do_reset(input bit full);
    int bad;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    if (full) begin
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 8'h20);
      check("rst_col", cursor_col, 0);
      check("rst_row", cursor_row, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    if (full) begin
      bad = 0;
      for (int i = 0; i < CELLS; i++) begin
        @(negedge clk);
        if (!(ram_we && ram_addr == ADDR_W'(i) && ram_wdata == 8'h20)) bad++;
      end
      check("init_bad_cycles", bad, 0);
      @(negedge clk);
      check("init_done_we", ram_we, 0);
      check("init_done_busy", busy, 0);
      check("init_done_col", cursor_col, 0);
      check("init_done_row", cursor_row, 0);
    end
  endtask

  initial begin
    model_reset();

    // Reset and full-screen clear
    do_reset(1);

    // Single character: write two edges after acceptance
    send(8'h41);
    expect_quiet("a_gap", 1);
    expect_write("a", 0, 8'h41);
    check("a_col", cursor_col, 1);
    wait_idle("a_idle", 50);

    // Line wrap at the last column
    send(8'h0D);
    wait_idle("wrap_cr", 50);
    for (int i = 0; i < COLS - 1; i++) begin
      send(8'h58);
      wait_idle("wrap_fill", 50);
    end
    send(8'h58);
    expect_quiet("wrap_gap", 1);
    expect_write("wrap_last", 79, 8'h58);
    check("wrap_col", cursor_col, 0);
    check("wrap_row", cursor_row, 1);
    for (int c = 0; c < COLS; c++) expect_write("wrap_clr", 80 + c, 8'h20);
    expect_quiet("wrap_end", 1);
    wait_idle("wrap_idle", 50);

    // Control characters
    do_reset(0);
    wait_idle("ctl_init", 3000);
    send(8'h41); wait_idle("ctl_a", 50);
    send(8'h42); wait_idle("ctl_b", 50);
    send(8'h43); wait_idle("ctl_c", 50);
    send(8'h08);
    expect_quiet("bs_gap", 1);
    expect_write("bs", 2, 8'h20);
    check("bs_col", cursor_col, 2);
    wait_idle("bs_idle", 50);
    send(8'h0D);
    expect_quiet("cr_nowrite", 4);
    check("cr_col", cursor_col, 0);
    send(8'h08);
    expect_quiet("bs0_nowrite", 4);
    check("bs0_col", cursor_col, 0);
    send(8'h41);
    wait_idle("bel_pre", 50);
    send(8'h07);
    expect_quiet("bel_nowrite", 4);
    check("bel_col", cursor_col, 1);
    check("bel_row", cursor_row, 0);

    // Bottom wrap back to row 0
    repeat (ROWS - 1) begin
      send(8'h0A);
      wait_idle("lf_step", 200);
    end
    check("bottom_row", cursor_row, 29);
    send(8'h0A);
    expect_quiet("lf_gap", 2);
    check("btm_col", cursor_col, 0);
    check("btm_row", cursor_row, 0);
    for (int c = 0; c < COLS; c++) expect_write("btm_clr", c, 8'h20);
    wait_idle("btm_idle", 50);

    // Byte arriving on the edge the pending byte is drained: no drop
    do_reset(0);
    repeat (9) @(negedge clk);
    data = 8'h51; drdy = 1'b1; model_byte(8'h51);
    @(negedge clk); drdy = 1'b0;
    repeat (CELLS - 10) @(negedge clk);
    data = 8'h52; drdy = 1'b1; model_byte(8'h52);
    @(negedge clk); drdy = 1'b0;
    wait_idle("same_edge_idle", 50);
    check("same_edge_ovf", overflow, 0);
    check("same_edge_col", cursor_col, 2);
    check("same_edge_addr", last_addr, 1);
    check("same_edge_data", last_data, 8'h52);

    // Two bytes during the init clear: second is dropped
    do_reset(0);
    repeat (9) @(negedge clk);
    data = 8'h61; drdy = 1'b1; model_byte(8'h61);
    @(negedge clk); drdy = 1'b0;
    repeat (9) @(negedge clk);
    data = 8'h62; drdy = 1'b1; m_ovf = 1'b1;
    @(negedge clk); drdy = 1'b0;
    wait_idle("drop_idle", 3000);
    check("drop_ovf", overflow, 1);
    check("drop_col", cursor_col, 1);
    check("drop_addr", last_addr, 0);
    check("drop_data", last_data, 8'h61);

    // Reset in the middle of a row clear
    send(8'h0A);
    repeat (22) @(negedge clk);
    check("rowclr_active", ram_we, 1);
    do_reset(1);

    // Randomized traffic, occasionally two bytes back to back
    for (int n = 0; n < 300; n++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) send(rand_byte());
      wait_idle("rand_idle", 400);
    end

    @(negedge clk);
    check("final_queue_empty", exp_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_text_writer.md
# uart_text_writer

Consumes bytes from the UART receiver (`uart_rec`: `drdy`/`data[7:0]`, 100 MHz `clk`, 9600 baud) and turns them into writes to the VGA text-mode character RAM. It tracks a cursor, interprets CR/LF/BS, wraps lines and rows, and blanks each newly entered row. The block sits between `uart_rec` and the character RAM write port that the VGA character renderer reads.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 30, rows per screen
- `ADDR_W`, 12, RAM address width; must satisfy COLS*ROWS ≤ 2^ADDR_W
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `drdy`  in  1  byte-ready from `uart_rec`; treated as a level, rising edge = new byte
- `data`  in  8  received byte, valid when `drdy` rises
- `ram_we`  out  1  character RAM write enable, registered
- `ram_addr`  out  ADDR_W  write address = row*COLS + col, registered
- `ram_wdata`  out  8  character code to write, registered
- `cursor_col`  out  $clog2(COLS)  current column
- `cursor_row`  out  $clog2(ROWS)  current row
- `busy`  out  1  high when state ≠ IDLE or a byte is pending
- `overflow`  out  1  sticky flag: a byte was dropped

## Operation
- **Edge detect:** `drdy_q` is registered. A byte is accepted at an edge where `drdy`=1 and `drdy_q`=0. `data` is latched into a 1-entry pending register and `pend_v` is set.
- **Pending register:**
  - If an accepted byte arrives while `pend_v`=1 and the FSM is not consuming it that cycle, the byte is dropped and `overflow` is set to 1.
  - `overflow` is cleared only by `rst`.
  - If the FSM consumes the pending byte on the same edge a new byte arrives, the new byte is loaded and no overflow occurs.
- **States:** INIT_CLR, IDLE, WRITE, ROW_CLR.
- **INIT_CLR** (entered on reset):
  - Writes 0x20 to addresses 0 .. COLS*ROWS-1, one per cycle.
  - Goes to IDLE after the last address.
  - Accepted bytes are held in the pending register.
- **IDLE:** if `pend_v`, consume the byte (clear `pend_v`) and go to WRITE.
- **WRITE** (one cycle), by byte value:
  - Printable 0x20–0x7E:
    - Write the byte at (row, col).
    - If col < COLS-1: col+1, back to IDLE.
    - Otherwise: col=0, row=(row+1) mod ROWS, go to ROW_CLR.
  - 0x0D (CR): col=0, no write, go to IDLE.
  - 0x0A (LF): col=0, row=(row+1) mod ROWS, no write, go to ROW_CLR.
  - 0x08 (BS):
    - If col > 0: col-1, write 0x20 at the new (row, col).
    - At col 0: ignored.
    - Go to IDLE.
  - Any other value (0x00–0x1F other than the above, 0x7F–0xFF): ignored, no cursor change, go to IDLE.
- **ROW_CLR:** writes 0x20 at row*COLS + 0 .. COLS-1 for the current (new) row, one per cycle, then goes to IDLE. The cursor does not move.
- **Bottom wrap:** row ROWS-1 advancing to row 0 clears row 0. There is no scrolling.
- **`rst` mid-operation:** an asserted `rst` in any state aborts that state. All registers reset and the block re-enters INIT_CLR.

## Timing
- **Reset values:**
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0x20
  - `cursor_col`=0, `cursor_row`=0
  - `overflow`=0, `busy`=1, `pend_v`=0, `drdy_q`=0
- **INIT_CLR:** the first `ram_we` pulse (addr 0) is registered at the first edge with `rst`=0. The clear takes exactly COLS*ROWS cycles with `ram_we` continuously high. `busy` drops on the cycle after the last write, provided no byte is pending.
- **Byte latency:**
  - Accept edge k: `pend_v` is set.
  - Edge k+1: IDLE→WRITE.
  - Edge k+2: `ram_we`=1 for exactly one cycle with addr/data; cursor updated on the same edge.
- **ROW_CLR:** `ram_we` stays high for COLS consecutive cycles, starting the edge after WRITE.
- `ram_we` is 0 in every cycle not listed above.

## Test plan
- **Reset/init:** release `rst` and count writes → 2400 writes of 0x20 at addresses 0..2399 in consecutive cycles; then `busy`=0, cursor (0,0).
- **Single character:** after init, send 0x41 (`drdy` rising edge) → one write, addr 0, data 0x41, two edges after acceptance; `cursor_col`=1.
- **Line wrap:** send 80 × 0x58 → last write at addr 79; cursor (0,1); then 80 writes of 0x20 at addresses 80..159.
- **Control characters:**
  - 0x41 0x42 0x43 then 0x08 → 0x20 written at addr 2, cursor col 2.
  - 0x0D → col 0, no write.
  - 0x08 at col 0 → no write.
  - 0x07 → no write, cursor unchanged.
- **Bottom wrap:** cursor at row 29, send 0x0A → cursor (0,0); clear writes at addresses 0..79.
- **Overflow and reset mid-clear:**
  - Two `drdy` edges during INIT_CLR → the first byte is written at addr 0 after init, the second is dropped, `overflow`=1.
  - Assert `rst` mid-ROW_CLR → all outputs at reset values and INIT_CLR restarts from addr 0.
